aes128_round_sequencer: RTL and testbench

//  Iterative-round controller for AES-128 encryption. Owns the 128-bit state register,

---
 rtl/aes128_round_sequencer.sv | 139 +++++++++++++
 tb/tb_aes128_round_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_round_sequencer.sv
// AES-128 iterative round sequencer: owns the cipher state, schedules round keys and the shared round unit.
// Optional abort input is compiled in when AES_SEQ_ABORT_EN is defined.
module aes128_round_sequencer #(
  parameter int unsigned NR     = 10,
  parameter int unsigned DATA_W = 128
) (
  input  logic              clk_i,
  input  logic              rst_ni,
`ifdef AES_SEQ_ABORT_EN
  input  logic              abort_i,
`endif
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] plain_text_i,
  output logic [3:0]        rk_idx_o,
  input  logic [DATA_W-1:0] rk_data_i,
  output logic [DATA_W-1:0] round_in_o,
  output logic [DATA_W-1:0] round_key_o,
  output logic              round_final_o,
  input  logic [DATA_W-1:0] round_out_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] cipher_text_o,
  output logic              busy_o
);

  localparam int unsigned RND_W = 4;
  localparam logic [RND_W-1:0] RND_LAST = RND_W'(NR);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [RND_W-1:0]    rnd_q, rnd_d;
  logic [DATA_W-1:0]   st_q, st_d;
  logic [DATA_W-1:0]   ct_q, ct_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                final_q, final_d;
  logic                abort_w;

`ifdef AES_SEQ_ABORT_EN
  assign abort_w = abort_i;
`else
  assign abort_w = 1'b0;
`endif

  // State register and all registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rnd_q       <= '0;
      st_q        <= '0;
      ct_q        <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      final_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      st_q        <= st_d;
      ct_q        <= ct_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      final_q     <= final_d;
    end
  end

  // Next-state logic; registered flags are derived from the next state so they line up with it
  always_comb begin
    state_d     = state_q;
    rnd_d       = rnd_q;
    st_d        = st_q;
    ct_d        = ct_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid_i && in_ready_q) begin
          st_d    = plain_text_i ^ rk_data_i;
          rnd_d   = RND_W'(1);
          state_d = RUN;
        end
      end
      RUN: begin
        st_d = round_out_i;
        if (rnd_q >= RND_LAST) begin
          ct_d        = round_out_i;
          out_valid_d = 1'b1;
          rnd_d       = '0;
          state_d     = DONE;
        end else begin
          rnd_d = rnd_q + RND_W'(1);
        end
      end
      DONE: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        rnd_d       = '0;
        out_valid_d = 1'b0;
      end
    endcase

    // Abort wins over both the last-round transition and the output handshake
    if (abort_w && (state_q != IDLE)) begin
      state_d     = IDLE;
      rnd_d       = '0;
      st_d        = '0;
      ct_d        = '0;
      out_valid_d = 1'b0;
    end

    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d == RUN) || (state_d == DONE);
    final_d    = (state_d == RUN) && (rnd_d == RND_LAST);
  end

  // rnd is held at zero in IDLE and DONE, so it doubles as the key index
  assign rk_idx_o      = rnd_q;
  assign round_in_o    = st_q;
  assign round_key_o   = rk_data_i;
  assign round_final_o = final_q;
  assign out_valid_o   = out_valid_q;
  assign in_ready_o    = in_ready_q;
  assign cipher_text_o = ct_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_aes128_round_sequencer.sv
// Bench for aes128_round_sequencer: provides key store and round unit, checks against an AES-128 model.
module tb_aes128_round_sequencer;

  typedef logic [127:0]        blk_t;
  typedef logic [10:0][127:0]  rk_set_t;

  typedef struct {
    blk_t key;
    blk_t pt;
    blk_t ct;
    int   stall;
  } vec_t;

  logic       clk;
  logic       rst_n;
`ifdef AES_SEQ_ABORT_EN
  logic       abort;
`endif
  logic       in_valid;
  logic       in_ready;
  blk_t       plain;
  logic [3:0] rk_idx;
  blk_t       rk_data;
  blk_t       round_in;
  blk_t       round_key;
  logic       round_final;
  blk_t       round_out;
  logic       out_valid;
  logic       out_ready;
  blk_t       cipher;
  logic       busy;

  rk_set_t    cur_rks;
  int         n_tests = 0;
  int         n_fail  = 0;

  aes128_round_sequencer #(.NR(10), .DATA_W(128)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
`ifdef AES_SEQ_ABORT_EN
    .abort_i       (abort),
`endif
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .plain_text_i  (plain),
    .rk_idx_o      (rk_idx),
    .rk_data_i     (rk_data),
    .round_in_o    (round_in),
    .round_key_o   (round_key),
    .round_final_o (round_final),
    .round_out_i   (round_out),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .cipher_text_o (cipher),
    .busy_o        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- AES-128 reference arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254, then the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv, base, e;
    inv = 8'h01; base = x; e = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) inv = gmul(inv, base);
      base = gmul(base, base);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] gb(input blk_t s, input int i);
    return s[127-8*i -: 8];
  endfunction

  function automatic blk_t sub_shift(input blk_t s);
    blk_t o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = sbox(gb(s, 4*((c+r)%4)+r));
    return o;
  endfunction

  function automatic blk_t mix(input blk_t s);
    blk_t o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = gb(s, 4*c); a1 = gb(s, 4*c+1); a2 = gb(s, 4*c+2); a3 = gb(s, 4*c+3);
      o[127-8*(4*c)   -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      o[127-8*(4*c+1) -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      o[127-8*(4*c+3) -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return o;
  endfunction

  function automatic rk_set_t key_exp(input blk_t key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rk_set_t     rks;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rks;
  endfunction

  function automatic blk_t aes_ref(input blk_t key, input blk_t pt);
    rk_set_t rks;
    blk_t    s;
    rks = key_exp(key);
    s = pt ^ rks[0];
    for (int r = 1; r < 10; r++) s = mix(sub_shift(s)) ^ rks[r];
    return sub_shift(s) ^ rks[10];
  endfunction

  // External key store and shared round unit seen by the sequencer
  always_comb rk_data = (rk_idx <= 4'd10) ? cur_rks[rk_idx] : '0;
  always_comb round_out = round_final ? (sub_shift(round_in) ^ round_key)
                                      : (mix(sub_shift(round_in)) ^ round_key);

  // ---------------- bench helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input blk_t act, input blk_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("in_ready_wait", blk_t'(in_ready), 128'd1);
  endtask

  task automatic start_block(input blk_t key, input blk_t pt);
    cur_rks = key_exp(key);
    wait_ready();
    chk("rk_idx_at_accept", blk_t'(rk_idx), 128'd0);
    plain    = pt;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    plain    = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Accept edge counted as cycle 1; out_valid is visible after cycle 11
  task automatic run_block(input vec_t v);
    logic trace_ok, stable_ok;
    out_ready = (v.stall == 0);
    start_block(v.key, v.pt);
    trace_ok = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      if (rk_idx !== 4'(k) || round_final !== (k == 10) || out_valid !== 1'b0 || busy !== 1'b1)
        trace_ok = 1'b0;
      tick();
    end
    chk("rk_trace", blk_t'(trace_ok), 128'd1);
    chk("out_valid_latency", blk_t'(out_valid), 128'd1);
    chk("cipher", cipher, v.ct);
    stable_ok = 1'b1;
    for (int s = 0; s < v.stall; s++) begin
      tick();
      if (out_valid !== 1'b1 || cipher !== v.ct || in_ready !== 1'b0 || busy !== 1'b1)
        stable_ok = 1'b0;
    end
    chk("hold_stable", blk_t'(stable_ok), 128'd1);
    out_ready = 1'b1;
    tick();
    chk("release_idle", blk_t'({busy, out_valid, in_ready}), 128'd1);
  endtask

  // ---------------- test sequence ----------------
  vec_t       vecs [8];
  blk_t       got [2];
  int         acc_cyc [2];
  int         acc_n, got_n, cyc;
  logic       acc;
  blk_t       key_a, pt0, pt1;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    plain     = '0;
    cur_rks   = '0;
`ifdef AES_SEQ_ABORT_EN
    abort     = 1'b0;
`endif
    #2;
    chk("rst_out_valid", blk_t'(out_valid), 128'd0);
    chk("rst_busy", blk_t'(busy), 128'd0);
    chk("rst_in_ready", blk_t'(in_ready), 128'd0);
    chk("rst_cipher", cipher, 128'd0);
    chk("rst_idx_final", blk_t'({rk_idx, round_final}), 128'd0);
    chk("rst_state_reg", round_in, 128'd0);
    tick();
    tick();
    rst_n = 1'b1;
    chk("in_ready_before_edge", blk_t'(in_ready), 128'd0);
    tick();
    chk("in_ready_after_edge", blk_t'(in_ready), 128'd1);

    // Known-answer vectors plus model-checked random blocks with random output stalls
    vecs[0].key = 128'h000102030405060708090a0b0c0d0e0f;
    vecs[0].pt  = 128'h00112233445566778899aabbccddeeff;
    vecs[0].ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    vecs[0].stall = 0;
    vecs[1].key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    vecs[1].pt  = 128'h3243f6a8885a308d313198a2e0370734;
    vecs[1].ct  = 128'h3925841d02dc09fbdc118597196a0b32;
    vecs[1].stall = 20;
    for (int i = 2; i < 8; i++) begin
      vecs[i].key   = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].pt    = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].ct    = aes_ref(vecs[i].key, vecs[i].pt);
      vecs[i].stall = int'($urandom_range(0, 3));
    end
    chk("model_fips_c1", aes_ref(vecs[0].key, vecs[0].pt), vecs[0].ct);
    for (int i = 0; i < 8; i++) run_block(vecs[i]);

    // Back-to-back: in_valid held high across two blocks
    key_a = {$urandom, $urandom, $urandom, $urandom};
    pt0   = {$urandom, $urandom, $urandom, $urandom};
    pt1   = {$urandom, $urandom, $urandom, $urandom};
    cur_rks   = key_exp(key_a);
    out_ready = 1'b1;
    wait_ready();
    plain = pt0; in_valid = 1'b1;
    cyc = 0; acc_n = 0; got_n = 0;
    for (int i = 0; i < 40 && got_n < 2; i++) begin
      acc = in_valid && in_ready;
      tick();
      cyc++;
      if (acc && acc_n < 2) begin
        acc_cyc[acc_n] = cyc;
        acc_n++;
        if (acc_n == 1) plain = pt1;
        else in_valid = 1'b0;
      end
      if (out_valid && got_n < 2) begin
        got[got_n] = cipher;
        got_n++;
      end
    end
    in_valid = 1'b0;
    chk("b2b_accepts", blk_t'(acc_n), 128'd2);
    chk("b2b_outputs", blk_t'(got_n), 128'd2);
    chk("b2b_spacing", blk_t'(acc_cyc[1] - acc_cyc[0]), 128'd12);
    chk("b2b_cipher0", got[0], aes_ref(key_a, pt0));
    chk("b2b_cipher1", got[1], aes_ref(key_a, pt1));
    tick();

    // Reset pulse in the middle of a block
    start_block(vecs[1].key, vecs[1].pt);
    for (int i = 0; i < 8 && rk_idx != 4'd5; i++) tick();
    chk("pre_reset_rnd", blk_t'(rk_idx), 128'd5);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_valid_busy", blk_t'({out_valid, busy, in_ready}), 128'd0);
    chk("midrun_rst_regs", round_in | cipher | blk_t'(rk_idx), 128'd0);
    tick();
    rst_n = 1'b1;
    chk("rerst_ready_before_edge", blk_t'(in_ready), 128'd0);
    tick();
    run_block(vecs[3]);

`ifdef AES_SEQ_ABORT_EN
    // Abort during the final round
    out_ready = 1'b1;
    start_block(vecs[0].key, vecs[0].pt);
    repeat (9) tick();
    chk("abort_setup_rnd", blk_t'(rk_idx), 128'd10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_final_flags", blk_t'({out_valid, busy, in_ready}), 128'd1);
    chk("abort_final_regs", cipher | round_in | blk_t'(rk_idx), 128'd0);
    tick();
    chk("abort_no_late_valid", blk_t'(out_valid), 128'd0);

    // Abort in DONE beats out_ready and clears the held cipher
    run_block(vecs[2]);
    start_block(vecs[0].key, vecs[0].pt);
    repeat (10) tick();
    chk("abort_done_setup", cipher, vecs[0].ct);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_done_cipher", cipher, 128'd0);
    chk("abort_done_flags", blk_t'({out_valid, busy}), 128'd0);

    // Abort is ignored while idle: the block is still accepted
    abort = 1'b1;
    start_block(vecs[0].key, vecs[0].pt);
    chk("abort_idle_ignored", blk_t'(busy), 128'd1);
    tick();
    abort = 1'b0;
    chk("abort_after_accept", blk_t'(busy), 128'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
